dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache placed between the pipeline's MEM-stage data port and the off-chip data memory. It replaces the single-cycle data memory path. Hits complete in the requesting cycle. Misses raise `cpu_stall_o` while a 256-bit block is written back and/or refilled over a request/acknowledge memory interface.

---
 rtl/dcache_ctrl.sv | 120 ++++++++++++
 tb/tb_dcache_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate data cache between the MEM stage and block memory.
// States: IDLE (hit service / miss detect) | WB (victim write-back) | ALLOC (block read) | REFILL (install line)
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int TAG_W = 23
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC, S_REFILL} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [255:0]      data_q [LINES];
  logic [255:0]      blk_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        word_lsb;
  logic              hit;
  logic              victim_dirty;
  logic              unused_addr_bits;

  assign req_tag          = cpu_addr_i[31 -: TAG_W];
  assign idx              = cpu_addr_i[5 +: IDX_W];
  assign word_lsb         = {cpu_addr_i[4:2], 5'b0};
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit = cpu_req_i & valid_q[idx] & (tag_q[idx] == req_tag) & (state_q == S_IDLE);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i && !hit) begin
          state_d = victim_dirty ? S_WB : S_ALLOC;
        end
      end
      S_WB:     if (mem_ack_i) state_d = S_ALLOC;
      S_ALLOC:  if (mem_ack_i) state_d = S_REFILL;
      S_REFILL: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_stall_o = 1'b1;
    cpu_data_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    case (state_q)
      S_IDLE: begin
        cpu_stall_o = cpu_req_i & ~hit;
        if (hit) cpu_data_o = data_q[idx][word_lsb +: 32];
      end
      S_WB: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {tag_q[idx], idx, 5'b0};
        mem_data_o = data_q[idx];
      end
      S_ALLOC: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_tag, idx, 5'b0};
      end
      default: ;
    endcase
  end

  // Only status bits are reset; tag/data contents are meaningless until valid is set.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == S_REFILL) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (hit && cpu_we_i) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_ALLOC && mem_ack_i) begin
      blk_q <= mem_data_i;
    end
    if (state_q == S_REFILL) begin
      data_q[idx] <= blk_q;
      tag_q[idx]  <= req_tag;
    end else if (hit && cpu_we_i) begin
      data_q[idx][word_lsb +: 32] <= cpu_data_i;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: expected memory transactions, stall counts and load data are
// queued per access and checked as the cache produces them, against a flat reference memory.
module tb_dcache_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
  } txn_t;

  txn_t         exp_q[$];
  int           exp_stall_q[$];
  logic [31:0]  exp_data_q[$];
  logic [255:0] dram [logic [31:0]];
  logic [31:0]  ref_mem [logic [31:0]];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] dram_block(input logic [31:0] b);
    logic [255:0] blk;
    if (dram.exists(b)) return dram[b];
    for (int w = 0; w < 8; w++) blk[32*w +: 32] = pat(b + 32'(4*w));
    return blk;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  // One CPU access, held until the stall clears; also plays the memory side.
  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int wb_dly, input int rd_dly);
    int stalls = 0;
    int req_cnt = 0;
    bit done = 0;
    bit bad;
    txn_t t;
    logic [31:0] got = '0;
    logic [31:0] e;
    int es;
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      #1;
      mem_ack_i = 1'b0;
      if (!cpu_stall_o) begin
        got = cpu_data_o;
        done = 1;
      end else begin
        stalls++;
        if (mem_req_o) begin
          req_cnt++;
          if (req_cnt == (mem_we_o ? wb_dly : rd_dly)) begin
            mem_ack_i = 1'b1;
            req_cnt = 0;
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL mem_txn: unexpected we=%0b addr=%h, none required", mem_we_o, mem_addr_o);
            end else begin
              t = exp_q.pop_front();
              if (mem_we_o !== t.we || mem_addr_o !== t.addr) begin
                miscompares++;
                $display("FAIL mem_txn: got we=%0b addr=%h, required we=%0b addr=%h",
                         mem_we_o, mem_addr_o, t.we, t.addr);
              end
            end
            if (mem_we_o) begin
              bad = 0;
              for (int w = 0; w < 8; w++)
                if (mem_data_o[32*w +: 32] !== ref_word(mem_addr_o + 32'(4*w))) bad = 1;
              vectors++;
              if (bad) begin
                miscompares++;
                $display("FAIL wb_block @%h: got %h", mem_addr_o, mem_data_o);
              end
              dram[mem_addr_o] = mem_data_o;
            end else begin
              mem_data_i = dram_block(mem_addr_o);
            end
          end
        end
      end
      @(posedge clk_i);
      @(negedge clk_i);
    end
    cpu_req_i = 1'b0;
    mem_ack_i = 1'b0;
    es = exp_stall_q.pop_front();
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL timeout addr=%h: stall never cleared, required %0d stall cycles", addr, es);
    end else if (stalls != es) begin
      miscompares++;
      $display("FAIL stall_cycles addr=%h: got %0d, required %0d", addr, stalls, es);
    end
    if (!we) begin
      e = exp_data_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL load_data addr=%h: got %h, required %h", addr, got, e);
      end
    end else begin
      ref_mem[{addr[31:2], 2'b00}] = wdata;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_txn addr=%h: %0d transactions left, required 0", addr, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_data_i = '0;
    mem_ack_i = 0; mem_data_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if ({mem_req_o, mem_we_o, cpu_stall_o} !== 3'b000 || mem_addr_o !== '0 ||
        mem_data_o !== '0 || cpu_data_o !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: req=%0b we=%0b stall=%0b addr=%h data=%h, required all 0",
               mem_req_o, mem_we_o, cpu_stall_o, mem_addr_o, cpu_data_o);
    end
    rst_i = 1'b1;
  endtask

  task automatic test_cold_miss;
    logic [255:0] blk = dram_block(32'h200);
    blk[63:32] = 32'hDEADBEEF;
    dram[32'h200] = blk;
    ref_mem[32'h204] = 32'hDEADBEEF;
    exp_q.push_back('{we: 1'b0, addr: 32'h200});
    exp_stall_q.push_back(5);
    exp_data_q.push_back(32'hDEADBEEF);
    cpu_op(1'b0, 32'h204, '0, 1, 3);
    exp_stall_q.push_back(0);
    exp_data_q.push_back(32'hDEADBEEF);
    cpu_op(1'b0, 32'h204, '0, 1, 3);
  endtask

  task automatic test_store_hit;
    exp_stall_q.push_back(0);
    cpu_op(1'b1, 32'h208, 32'h12345678, 1, 3);
    exp_stall_q.push_back(0);
    exp_data_q.push_back(32'h12345678);
    cpu_op(1'b0, 32'h208, '0, 1, 3);
  endtask

  task automatic test_dirty_evict;
    exp_q.push_back('{we: 1'b1, addr: 32'h200});
    exp_q.push_back('{we: 1'b0, addr: 32'h1200});
    exp_stall_q.push_back(2 + 3 + 2);
    exp_data_q.push_back(ref_word(32'h1208));
    cpu_op(1'b0, 32'h1208, '0, 2, 3);
    vectors++;
    if (dram[32'h200][95:64] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL wb_word2: got %h, required 12345678", dram[32'h200][95:64]);
    end
  endtask

  task automatic test_store_miss;
    exp_q.push_back('{we: 1'b0, addr: 32'h420});
    exp_stall_q.push_back(2 + 2);
    cpu_op(1'b1, 32'h424, 32'hA5A5A5A5, 1, 2);
    exp_stall_q.push_back(0);
    exp_data_q.push_back(32'hA5A5A5A5);
    cpu_op(1'b0, 32'h424, '0, 1, 2);
    exp_q.push_back('{we: 1'b1, addr: 32'h420});
    exp_q.push_back('{we: 1'b0, addr: 32'h2420});
    exp_stall_q.push_back(1 + 1 + 2);
    exp_data_q.push_back(ref_word(32'h2424));
    cpu_op(1'b0, 32'h2424, '0, 1, 1);
  endtask

  task automatic test_reset_mid_alloc;
    bit seen = 0;
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h5008;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (mem_req_o) seen = 1;
      else begin @(posedge clk_i); @(negedge clk_i); end
    end
    vectors++;
    if (!seen || mem_we_o !== 1'b0 || mem_addr_o !== 32'h5000) begin
      miscompares++;
      $display("FAIL alloc_req: seen=%0b we=%0b addr=%h, required read of 00005000", seen, mem_we_o, mem_addr_o);
    end
    #1 rst_i = 1'b0;
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== '0) begin
      miscompares++;
      $display("FAIL async_abort: req=%0b addr=%h, required 0", mem_req_o, mem_addr_o);
    end
    cpu_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    ref_mem.delete();
    foreach (dram[b])
      for (int w = 0; w < 8; w++) ref_mem[b + 32'(4*w)] = dram[b][32*w +: 32];
    exp_q.push_back('{we: 1'b0, addr: 32'h1200});
    exp_stall_q.push_back(2 + 2);
    exp_data_q.push_back(ref_word(32'h1208));
    cpu_op(1'b0, 32'h1208, '0, 1, 2);
  endtask

  task automatic test_ack_edges;
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    mem_data_i = '1;
    @(posedge clk_i);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ack: req=%0b stall=%0b, required 0 0", mem_req_o, cpu_stall_o);
    end
    exp_stall_q.push_back(0);
    exp_data_q.push_back(ref_word(32'h1208));
    cpu_op(1'b0, 32'h1208, '0, 1, 1);
    exp_q.push_back('{we: 1'b0, addr: 32'hFFFF_FFE0});
    exp_stall_q.push_back(3);
    exp_data_q.push_back(ref_word(32'hFFFF_FFFC));
    cpu_op(1'b0, 32'hFFFF_FFFC, '0, 1, 1);
    exp_stall_q.push_back(0);
    cpu_op(1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 1, 1);
    exp_stall_q.push_back(0);
    exp_data_q.push_back(32'h0BAD_F00D);
    cpu_op(1'b0, 32'hFFFF_FFFC, '0, 1, 1);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_store_hit();
    test_dirty_evict();
    test_store_miss();
    test_reset_mid_alloc();
    test_ack_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
